// File: rtl/cc_pkg.sv
// cc_pkg: shared coefficient indices, sequencer states and identity-matrix helper.
package cc_pkg;
  localparam int CC_COEF_NUM = 12;
  localparam int CC_CTRL_W = 32;
  localparam int CC_A11 = 0;
  localparam int CC_A12 = 1;
  localparam int CC_A13 = 2;
  localparam int CC_A14 = 3;
  localparam int CC_A21 = 4;
  localparam int CC_A22 = 5;
  localparam int CC_A23 = 6;
  localparam int CC_A24 = 7;
  localparam int CC_A31 = 8;
  localparam int CC_A32 = 9;
  localparam int CC_A33 = 10;
  localparam int CC_A34 = 11;
  typedef enum logic [1:0] {IDLE, ARMED, DRAIN, WRITE} cc_seq_state_t;
  function automatic logic [CC_CTRL_W-1:0] cc_identity(input int idx, input int fract_width = 10);
    return (idx == CC_A11 || idx == CC_A22 || idx == CC_A33) ? CC_CTRL_W'(1) << fract_width : '0;
  endfunction
endpackage

// File: rtl/cc_ctrl_if.sv
// cc_ctrl_if: coefficient load port of the colour corrector.
interface cc_ctrl_if;
  import cc_pkg::*;
  logic                 coef_lock;
  logic [3:0]           coef_sel;
  logic [CC_CTRL_W-1:0] coef;
  modport master (output coef_lock, coef_sel, coef);
  modport slave  (input coef_lock, coef_sel, coef);
endinterface

// File: rtl/cc_coef_sequencer.sv
// cc_coef_sequencer: tear-free 3x4 matrix load, replayed at a frame boundary once the corrector drains.
module cc_coef_sequencer
  import cc_pkg::*;
#(
  parameter int PX_WIDTH       = 10,
  parameter int FRACT_WIDTH    = 10,
  parameter int INFLIGHT_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          shadow_wr_i,
  input  logic [3:0]                    shadow_sel_i,
  input  logic [PX_WIDTH+FRACT_WIDTH:0] shadow_data_i,
  input  logic                          commit_i,
  input  logic                          apply_now_i,
  input  logic                          in_tvalid_i,
  input  logic                          in_tuser_i,
  input  logic                          in_hs_i,
  input  logic                          out_hs_i,
  output logic                          hold_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          commit_drop_o,
  cc_ctrl_if.master                     cc_ctrl_o
);
  localparam int COEF_WIDTH = PX_WIDTH + FRACT_WIDTH;
  logic [COEF_WIDTH:0]         shadow [CC_COEF_NUM];
  logic [COEF_WIDTH:0]         bank   [CC_COEF_NUM];
  logic [INFLIGHT_WIDTH-1:0]   inflight;
  logic                        drained;
  cc_seq_state_t               state;
  assign drained = inflight == '0 && !in_hs_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= IDLE;
      inflight            <= '0;
      hold_o              <= 1'b0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      commit_drop_o       <= 1'b0;
      cc_ctrl_o.coef_lock <= 1'b0;
      cc_ctrl_o.coef_sel  <= '0;
      cc_ctrl_o.coef      <= '0;
      for (int i = 0; i < CC_COEF_NUM; i++) begin
        shadow[i] <= (COEF_WIDTH+1)'(cc_identity(i, FRACT_WIDTH));
        bank[i]   <= (COEF_WIDTH+1)'(cc_identity(i, FRACT_WIDTH));
      end
    end else begin
      inflight <= (in_hs_i && !out_hs_i && ~&inflight) ? inflight + 1'b1 :
                  (out_hs_i && !in_hs_i && |inflight) ? inflight - 1'b1 : inflight;
      done_o        <= 1'b0;
      commit_drop_o <= commit_i && state != IDLE;
      if (shadow_wr_i && shadow_sel_i < 4'(CC_COEF_NUM)) shadow[shadow_sel_i] <= shadow_data_i;
      case (state)
        IDLE: if (commit_i) begin
          bank   <= shadow;
          state  <= apply_now_i ? DRAIN : ARMED;
          hold_o <= 1'b1;
          busy_o <= 1'b1;
        end
        ARMED: if ((in_tvalid_i && in_tuser_i) || apply_now_i) state <= DRAIN;
        DRAIN: if (drained) begin
          state               <= WRITE;
          cc_ctrl_o.coef_lock <= 1'b1;
          cc_ctrl_o.coef_sel  <= '0;
          cc_ctrl_o.coef      <= CC_CTRL_W'(bank[0]);
        end
        WRITE: if (cc_ctrl_o.coef_sel == 4'(CC_COEF_NUM - 1)) begin
          state               <= IDLE;
          cc_ctrl_o.coef_lock <= 1'b0;
          cc_ctrl_o.coef_sel  <= '0;
          cc_ctrl_o.coef      <= '0;
          done_o              <= 1'b1;
          hold_o              <= 1'b0;
          busy_o              <= 1'b0;
        end else begin
          cc_ctrl_o.coef_sel <= cc_ctrl_o.coef_sel + 4'd1;
          cc_ctrl_o.coef     <= CC_CTRL_W'(bank[cc_ctrl_o.coef_sel + 4'd1]);
        end
      endcase
    end
  end
endmodule
